filter_coef_ctrl: RTL and testbench
===================================

Name: filter_coef_ctrl

Overview:
- Configuration controller for the 5x5 convolution datapath. Owns the 25 filter coefficients and the bypass control.
- Accepts a streamed coefficient load through a valid/ready handshake into a shadow bank.
- Commits the shadow bank to the active bank only at a vertical-sync rising edge, so a frame is never filtered with mixed coefficients.
- Active bank drives the coefficient and bypass inputs of the filter top.

Parameters:
- COEF_WIDTH, 10, coefficient width in bits.
- NUM_TAPS, 25, kernel taps (5x5); the index counter width is 5.
- COEF_FRAC, 6, fractional bits; sets the reset value of the centre tap to 1<<COEF_FRAC.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_vs  in  1  vertical sync of the video input, same as the filter input.
- i_cfg_start  in  1  pulse; begins a new load sequence.
- i_cfg_valid  in  1  coefficient word valid.
- o_cfg_ready  out  1  controller can accept a coefficient word.
- i_cfg_data  in  COEF_WIDTH  coefficient word, in raster order c00..c44.
- i_bypass_req  in  1  requested bypass value, applied at the next commit.
- o_bypass  out  1  active bypass, to the filter.
- o_coef  out  NUM_TAPS*COEF_WIDTH  active bank, flat; tap k occupies [k*COEF_WIDTH +: COEF_WIDTH] with k = row*5 + col.
- o_pending  out  1  shadow bank complete and waiting for vs.
- o_update  out  1  one-cycle pulse when the active bank is updated.
- o_err  out  1  sticky error flag.
- i_rd_addr  in  5  readback tap index (used only with the optional feature).
- o_rd_data  out  COEF_WIDTH  readback data.

Behaviour:
- Reset values (rst=1 at a clk edge):
  - state=IDLE, index=0.
  - Active and shadow banks: all taps 0 except tap 12, which is 1<<COEF_FRAC (identity kernel).
  - o_bypass=1, o_pending=0, o_update=0, o_err=0, o_cfg_ready=0, o_rd_data=0.
  - vs_d=0.
- vs edge: vs_d is a register of i_vs. A rising edge is i_vs & ~vs_d, evaluated every cycle.
- States:
  - IDLE:
    - o_cfg_ready=0.
    - i_cfg_start -> LOAD, index=0, o_err cleared.
    - i_cfg_valid is ignored.
  - LOAD:
    - o_cfg_ready=1.
    - On valid&ready: shadow[index] <= i_cfg_data and index++.
    - The write at index=24 moves the state to PENDING and resets index to 0.
  - PENDING:
    - o_cfg_ready=0, o_pending=1.
    - On a vs rising edge in cycle N: active <= shadow and o_bypass <= i_bypass_req, both visible in cycle N+1.
    - In the same cycle N: o_update=1 in N+1, state -> IDLE.
- Latency: the 25th accepted word sits at least 1 cycle before commit. A vs edge in the same cycle as the 25th write does not commit; the commit waits for the next vs edge.
- Simultaneous events:
  - i_cfg_start in LOAD or PENDING restarts: LOAD, index=0, any pending commit aborted, o_err=1.
  - i_cfg_start in the same cycle as a PENDING vs edge: start wins, no commit, o_err=1.
- Handshake:
  - i_cfg_valid without ready is discarded with no error.
  - i_cfg_data is sampled only on valid&ready.
- Bypass-only change: i_bypass_req is also sampled at every vs rising edge in IDLE, with o_bypass updated and no o_update pulse. Bypass changes are therefore always frame-aligned.
- Active bank is static except at a commit. The shadow bank is never visible on o_coef.
- Reset mid-load: everything returns to reset values, including the active bank.

Optional Feature:
- Macro: FILTER_COEF_READBACK_EN.
- Defined: o_rd_data is registered active[i_rd_addr], with 1-cycle latency. For i_rd_addr >= 25, o_rd_data = 0.
- Undefined: o_rd_data is tied to 0 and i_rd_addr is unused.

Test Plan:
- Reset: hold rst 2 cycles -> o_bypass=1, o_coef tap12=64, all other taps 0, o_cfg_ready=0, o_err=0.
- Full load and commit:
  - Stimulus: start, then 25 words 1..25 with valid held high and i_bypass_req=0.
  - Required: o_pending=1 after the 25th word. o_coef is unchanged until the i_vs rising edge, then updates 1 cycle later to taps 1..25, with o_bypass=0 and a single o_update pulse.
- Valid gaps: same load with valid toggling 1/0 -> identical result, 25 writes counted, no error.
- Abort:
  - Stimulus: start, 10 words, start again, then 25 words of 0x3FF.
  - Required: o_err=1 after the second start. The active bank becomes all 0x3FF at the next vs edge. o_err clears on the next start.
- Edge coincidence:
  - Stimulus: 25th word accepted in the same cycle as an i_vs rise.
  - Required: no update on that edge; commit happens at the following vs rise.
- Readback (with FILTER_COEF_READBACK_EN) after the full-load test:
  - i_rd_addr=0 -> o_rd_data=1 one cycle later.
  - i_rd_addr=24 -> 25.
  - i_rd_addr=30 -> 0.

Source files
------------

// File: rtl/filter_coef_ctrl_if.sv
// ============================================================================
// Module      : filter_coef_ctrl_if
// Description : Coefficient-load handshake bundle (start, valid/ready, data).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface filter_coef_ctrl_if #(
    parameter int COEF_WIDTH = 10
);
    logic                  i_cfg_start;
    logic                  i_cfg_valid;
    logic                  o_cfg_ready;
    logic [COEF_WIDTH-1:0] i_cfg_data;

    modport master (
        output i_cfg_start,
        output i_cfg_valid,
        output i_cfg_data,
        input  o_cfg_ready
    );

    modport slave (
        input  i_cfg_start,
        input  i_cfg_valid,
        input  i_cfg_data,
        output o_cfg_ready
    );
endinterface

`default_nettype wire

// File: rtl/filter_coef_ctrl.sv
// ============================================================================
// Module      : filter_coef_ctrl
// Description : 5x5 filter coefficient controller; shadow bank loaded by
//               handshake, committed to the active bank on a vsync rise.
//               Optional readback port enabled by FILTER_COEF_READBACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module filter_coef_ctrl #(
    parameter int COEF_WIDTH = 10,
    parameter int NUM_TAPS   = 25,
    parameter int COEF_FRAC  = 6
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    input  wire logic                           i_vs,
    filter_coef_ctrl_if.slave                   cfg,
    input  wire logic                           i_bypass_req,
    output logic                                o_bypass,
    output logic [NUM_TAPS*COEF_WIDTH-1:0]      o_coef,
    output logic                                o_pending,
    output logic                                o_update,
    output logic                                o_err,
    input  wire logic [4:0]                     i_rd_addr,
    output logic [COEF_WIDTH-1:0]               o_rd_data
);

    localparam int                    c_CENTRE   = NUM_TAPS / 2;
    localparam logic [COEF_WIDTH-1:0] c_UNITY    = COEF_WIDTH'(1) << COEF_FRAC;
    localparam logic [4:0]            c_LAST_IDX = 5'(NUM_TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_PENDING = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [4:0]            idx_q, idx_d;
    logic                  err_q, err_d;
    logic                  bypass_q, bypass_d;
    logic                  update_q, update_d;
    logic                  vs_q;
    logic [COEF_WIDTH-1:0] shadow_q [NUM_TAPS];
    logic [COEF_WIDTH-1:0] active_q [NUM_TAPS];

    logic w_vs_rise;
    logic w_shadow_we;
    logic w_commit;
    logic w_ready;
    logic w_pending;

    assign w_vs_rise = i_vs & ~vs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            err_q    <= 1'b0;
            bypass_q <= 1'b1;
            update_q <= 1'b0;
            vs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            bypass_q <= bypass_d;
            update_q <= update_d;
            vs_q     <= i_vs;
        end
    end

    // A restart always wins over a write or a commit in the same cycle.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_d       = err_q;
        bypass_d    = bypass_q;
        update_d    = 1'b0;
        w_shadow_we = 1'b0;
        w_commit    = 1'b0;
        w_ready     = 1'b0;
        w_pending   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg.i_cfg_start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end else if (w_vs_rise) begin
                    bypass_d = i_bypass_req;
                end
            end
            S_LOAD: begin
                w_ready = 1'b1;
                if (cfg.i_cfg_start) begin
                    idx_d = '0;
                    err_d = 1'b1;
                end else if (cfg.i_cfg_valid) begin
                    w_shadow_we = 1'b1;
                    if (idx_q == c_LAST_IDX) begin
                        state_d = S_PENDING;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            S_PENDING: begin
                w_pending = 1'b1;
                if (cfg.i_cfg_start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    err_d   = 1'b1;
                end else if (w_vs_rise) begin
                    w_commit = 1'b1;
                    bypass_d = i_bypass_req;
                    update_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                shadow_q[k] <= (k == c_CENTRE) ? c_UNITY : '0;
                active_q[k] <= (k == c_CENTRE) ? c_UNITY : '0;
            end
        end else begin
            if (w_shadow_we) begin
                shadow_q[idx_q] <= cfg.i_cfg_data;
            end
            if (w_commit) begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    active_q[k] <= shadow_q[k];
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_TAPS; k++) begin : g_coef
            assign o_coef[k*COEF_WIDTH +: COEF_WIDTH] = active_q[k];
        end
    endgenerate

    assign cfg.o_cfg_ready = w_ready;
    assign o_pending       = w_pending;
    assign o_update        = update_q;
    assign o_err           = err_q;
    assign o_bypass        = bypass_q;

`ifdef FILTER_COEF_READBACK_EN
    logic [COEF_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (i_rd_addr < 5'(NUM_TAPS)) begin
            rd_data_q <= active_q[i_rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign o_rd_data = rd_data_q;
`else
    logic w_unused_rd_addr;
    assign w_unused_rd_addr = ^i_rd_addr;
    assign o_rd_data        = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_filter_coef_ctrl.sv
// ============================================================================
// Module      : tb_filter_coef_ctrl
// Description : Scoreboard bench for filter_coef_ctrl; commits are checked by
//               a monitor popping expected banks queued by the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_filter_coef_ctrl;

    localparam int CW = 10;
    localparam int NT = 25;

    typedef logic [NT*CW-1:0] bank_t;
    typedef struct {
        bank_t coef;
        logic  byp;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vs  = 1'b0;
    logic          bypass_req = 1'b0;
    logic [4:0]    rd_addr = '0;
    logic          o_bypass;
    bank_t         o_coef;
    logic          o_pending;
    logic          o_update;
    logic          o_err;
    logic [CW-1:0] o_rd_data;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    filter_coef_ctrl_if #(.COEF_WIDTH(CW)) cfg_if ();

    filter_coef_ctrl #(
        .COEF_WIDTH (CW),
        .NUM_TAPS   (NT),
        .COEF_FRAC  (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_vs         (vs),
        .cfg          (cfg_if.slave),
        .i_bypass_req (bypass_req),
        .o_bypass     (o_bypass),
        .o_coef       (o_coef),
        .o_pending    (o_pending),
        .o_update     (o_update),
        .o_err        (o_err),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (o_rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input bank_t act, input bank_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bank_t identity_bank();
        bank_t b = '0;
        b[12*CW +: CW] = 10'd64;
        return b;
    endfunction

    function automatic bank_t ramp_bank();
        bank_t b = '0;
        for (int k = 0; k < NT; k++) b[k*CW +: CW] = CW'(k + 1);
        return b;
    endfunction

    function automatic bank_t fill_bank(input logic [CW-1:0] v);
        bank_t b = '0;
        for (int k = 0; k < NT; k++) b[k*CW +: CW] = v;
        return b;
    endfunction

    // Every update pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && o_update) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_update: got update pulse expected none");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("commit_coef", o_coef, e.coef);
                chk("commit_bypass", bank_t'(o_bypass), bank_t'(e.byp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        cfg_if.i_cfg_start = 1'b1;
        tick();
        cfg_if.i_cfg_start = 1'b0;
    endtask

    task automatic send_words(input int n, input bit use_const, input logic [CW-1:0] val,
                              input int first, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int w;
            if (gaps && (i % 2 == 1)) begin
                cfg_if.i_cfg_valid = 1'b0;
                cfg_if.i_cfg_data  = 10'h2AA;
                tick();
            end
            cfg_if.i_cfg_valid = 1'b1;
            cfg_if.i_cfg_data  = use_const ? val : CW'(first + i);
            w = 0;
            while (!cfg_if.o_cfg_ready && w < 20) begin
                tick();
                w++;
            end
            if (w == 20) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: got ready=0 expected ready=1");
            end
            tick();
        end
        cfg_if.i_cfg_valid = 1'b0;
    endtask

    task automatic vs_commit(input bank_t coef, input logic byp);
        exp_t e;
        int   w;
        e.coef = coef;
        e.byp  = byp;
        exp_q.push_back(e);
        bypass_req = byp;
        vs = 1'b1;
        tick();
        chk("update_latency", bank_t'(o_update), bank_t'(1'b1));
        vs = 1'b0;
        w = 0;
        while (exp_q.size() != 0 && w < 10) begin
            tick();
            w++;
        end
        chk("commit_seen", bank_t'(exp_q.size()), bank_t'(0));
        chk("pending_cleared", bank_t'(o_pending), bank_t'(1'b0));
    endtask

    initial begin
        cfg_if.i_cfg_start = 1'b0;
        cfg_if.i_cfg_valid = 1'b0;
        cfg_if.i_cfg_data  = '0;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        chk("rst_coef", o_coef, identity_bank());
        chk("rst_bypass", bank_t'(o_bypass), bank_t'(1'b1));
        chk("rst_ready", bank_t'(cfg_if.o_cfg_ready), bank_t'(1'b0));
        chk("rst_err", bank_t'(o_err), bank_t'(1'b0));
        chk("rst_pending", bank_t'(o_pending), bank_t'(1'b0));
        chk("rst_rd_data", bank_t'(o_rd_data), bank_t'(0));

        // Full load with continuous valid
        bypass_req = 1'b0;
        start_pulse();
        chk("load_ready", bank_t'(cfg_if.o_cfg_ready), bank_t'(1'b1));
        send_words(25, 1'b0, '0, 1, 1'b0);
        chk("full_pending", bank_t'(o_pending), bank_t'(1'b1));
        chk("full_ready_low", bank_t'(cfg_if.o_cfg_ready), bank_t'(1'b0));
        tick();
        tick();
        chk("full_coef_held", o_coef, identity_bank());
        vs_commit(ramp_bank(), 1'b0);
        chk("full_err", bank_t'(o_err), bank_t'(1'b0));

`ifdef FILTER_COEF_READBACK_EN
        rd_addr = 5'd0;
        tick();
        chk("rd_addr0", bank_t'(o_rd_data), bank_t'(1));
        rd_addr = 5'd24;
        tick();
        chk("rd_addr24", bank_t'(o_rd_data), bank_t'(25));
        rd_addr = 5'd30;
        tick();
        chk("rd_addr30", bank_t'(o_rd_data), bank_t'(0));
`else
        rd_addr = 5'd3;
        tick();
        chk("rd_tied_zero", bank_t'(o_rd_data), bank_t'(0));
`endif

        // Valid gaps: pending only after the 25th accepted word
        start_pulse();
        send_words(24, 1'b0, '0, 1, 1'b1);
        chk("gaps_not_pending_24", bank_t'(o_pending), bank_t'(1'b0));
        send_words(1, 1'b0, '0, 25, 1'b1);
        chk("gaps_pending_25", bank_t'(o_pending), bank_t'(1'b1));
        chk("gaps_err", bank_t'(o_err), bank_t'(1'b0));
        vs_commit(ramp_bank(), 1'b1);

        // Bypass-only change in IDLE, and valid ignored in IDLE
        bypass_req = 1'b0;
        vs = 1'b1;
        tick();
        vs = 1'b0;
        tick();
        chk("idle_bypass", bank_t'(o_bypass), bank_t'(1'b0));
        chk("idle_coef_static", o_coef, ramp_bank());
        cfg_if.i_cfg_valid = 1'b1;
        cfg_if.i_cfg_data  = 10'h155;
        tick();
        tick();
        chk("idle_ready", bank_t'(cfg_if.o_cfg_ready), bank_t'(1'b0));
        cfg_if.i_cfg_valid = 1'b0;
        chk("idle_valid_ignored", bank_t'(o_pending), bank_t'(1'b0));

        // Abort and restart
        start_pulse();
        send_words(10, 1'b1, 10'd7, 0, 1'b0);
        start_pulse();
        chk("abort_err", bank_t'(o_err), bank_t'(1'b1));
        chk("abort_ready", bank_t'(cfg_if.o_cfg_ready), bank_t'(1'b1));
        send_words(25, 1'b1, 10'h3FF, 0, 1'b0);
        chk("abort_pending", bank_t'(o_pending), bank_t'(1'b1));
        vs_commit(fill_bank(10'h3FF), 1'b1);
        chk("abort_err_sticky", bank_t'(o_err), bank_t'(1'b1));
        start_pulse();
        chk("err_cleared", bank_t'(o_err), bank_t'(1'b0));

        // vs rise coincident with the 25th write must not commit
        send_words(24, 1'b0, '0, 1, 1'b0);
        bypass_req = 1'b0;
        cfg_if.i_cfg_valid = 1'b1;
        cfg_if.i_cfg_data  = 10'd25;
        vs = 1'b1;
        tick();
        cfg_if.i_cfg_valid = 1'b0;
        tick();
        chk("coinc_no_update", bank_t'(o_update), bank_t'(1'b0));
        chk("coinc_pending", bank_t'(o_pending), bank_t'(1'b1));
        chk("coinc_coef_held", o_coef, fill_bank(10'h3FF));
        chk("coinc_bypass_held", bank_t'(o_bypass), bank_t'(1'b1));
        vs = 1'b0;
        tick();
        vs_commit(ramp_bank(), 1'b0);

        // Reset mid-load restores the identity kernel
        start_pulse();
        send_words(5, 1'b1, 10'h111, 0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("midrst_coef", o_coef, identity_bank());
        chk("midrst_bypass", bank_t'(o_bypass), bank_t'(1'b1));
        chk("midrst_ready", bank_t'(cfg_if.o_cfg_ready), bank_t'(1'b0));
        chk("midrst_pending", bank_t'(o_pending), bank_t'(1'b0));

        tick();
        tick();
        chk("queue_drained", bank_t'(exp_q.size()), bank_t'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
